ofm_drain_buffer: RTL

- Double-buffered output-tile buffer between the systolic array result rows and the OFM write path.
- Collects SYSTOLIC_SIZE result rows into a tile. Row r is output channel r and holds SYSTOLIC_SIZE consecutive pixels.
- Per tile, issues a one-cycle write pulse to the OFM address controller, then streams the rows one per cycle, in channel order, aligned with the address sequence.
- Ping-pong banks let the array fill one tile while the previous tile drains.

---
 rtl/ofm_drain_buffer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ofm_drain_buffer.sv
// ofm_drain_buffer
// Ping-pong tile buffer between the systolic array result rows and the OFM
// write path. One bank collects SYSTOLIC_SIZE result rows (row r = output
// channel r) while the other bank drains. A drain starts with a one-cycle
// write pulse, then streams one row per cycle in channel order, then waits
// two idle cycles so the address controller can settle.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a valid result row
//   in_data    result row, pixel 0 in the LSBs
//   in_ready   buffer can accept a row this cycle
//   write      one-cycle pulse that starts an OFM address sequence
//   out_valid  out_data holds a valid row
//   out_data   row being written to OFM memory (holds when out_valid = 0)
//   tile_done  one-cycle pulse on the last drain beat of a tile
//   busy       any bank full, or drain FSM not idle
module ofm_drain_buffer #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] in_data,
  output logic                                in_ready,
  output logic                                write,
  output logic                                out_valid,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                                tile_done,
  output logic                                busy
);

  localparam int ROW_W = SYSTOLIC_SIZE * DATA_WIDTH;
  localparam int CW    = $clog2(SYSTOLIC_SIZE);
  localparam logic [CW-1:0] LAST_IDX = CW'(SYSTOLIC_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Bank storage: no reset, contents are only read after a full fill.
  logic [ROW_W-1:0] mem_r [2][SYSTOLIC_SIZE];

  logic [1:0]       full_r, full_s;
  logic             fill_sel_r;
  logic [CW-1:0]    fill_cnt_r;
  logic             drain_sel_r, drain_sel_s;
  logic [CW-1:0]    drain_cnt_r, drain_cnt_s;
  logic             gap_cnt_r, gap_cnt_s;
  state_t           state_r, state_s;
  logic             accept_s;
  logic             fill_last_s;
  logic             drain_last_s;

  logic             write_r;
  logic             out_valid_r;
  logic             tile_done_r;
  logic             busy_r;
  logic [ROW_W-1:0] out_data_r;

  // The fill target can never be the draining bank: that bank is full.
  assign in_ready    = !full_r[fill_sel_r];
  assign accept_s    = in_valid && in_ready;
  assign fill_last_s = accept_s && (fill_cnt_r == LAST_IDX);

  assign write     = write_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign tile_done = tile_done_r;
  assign busy      = busy_r;

  // Row storage write on every accepted row.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[fill_sel_r][fill_cnt_r] <= in_data;
    end
  end

  // Fill-side row counter and bank select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_r <= {CW{1'b0}};
      fill_sel_r <= 1'b0;
    end else if (fill_last_s) begin
      fill_cnt_r <= {CW{1'b0}};
      fill_sel_r <= ~fill_sel_r;
    end else if (accept_s) begin
      fill_cnt_r <= fill_cnt_r + 1'b1;
    end else begin
      fill_cnt_r <= fill_cnt_r;
    end
  end

  // Drain FSM next-state logic and bank full-flag update.
  always_comb begin
    state_s      = state_r;
    drain_cnt_s  = drain_cnt_r;
    drain_sel_s  = drain_sel_r;
    gap_cnt_s    = gap_cnt_r;
    drain_last_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (full_r[drain_sel_r]) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        drain_cnt_s = {CW{1'b0}};
        state_s     = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == LAST_IDX) begin
          drain_last_s = 1'b1;
          drain_cnt_s  = {CW{1'b0}};
          drain_sel_s  = ~drain_sel_r;
          gap_cnt_s    = 1'b0;
          state_s      = ST_GAP;
        end else begin
          drain_cnt_s = drain_cnt_r + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r) begin
          gap_cnt_s = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          gap_cnt_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Set and clear always hit different banks, so both can apply at once.
    full_s = full_r;
    if (fill_last_s) begin
      full_s[fill_sel_r] = 1'b1;
    end else begin
      full_s[fill_sel_r] = full_r[fill_sel_r];
    end
    if (drain_last_s) begin
      full_s[drain_sel_r] = 1'b0;
    end else begin
      full_s[drain_sel_r] = full_s[drain_sel_r];
    end
  end

  // Drain FSM state, counters and full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= {CW{1'b0}};
      drain_sel_r <= 1'b0;
      gap_cnt_r   <= 1'b0;
      full_r      <= 2'b00;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
      drain_sel_r <= drain_sel_s;
      gap_cnt_r   <= gap_cnt_s;
      full_r      <= full_s;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_r     <= 1'b0;
      out_valid_r <= 1'b0;
      tile_done_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= {ROW_W{1'b0}};
    end else begin
      write_r     <= (state_s == ST_START);
      out_valid_r <= (state_s == ST_DRAIN);
      tile_done_r <= (state_s == ST_DRAIN) && (drain_cnt_s == LAST_IDX);
      busy_r      <= (|full_s) || (state_s != ST_IDLE);
      if (state_s == ST_DRAIN) begin
        out_data_r <= mem_r[drain_sel_r][drain_cnt_s];
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

endmodule
